// File: rtl/ppu_pkg.sv
// Shared types, VRAM base addresses and address helpers for the background pixel fetcher.
// Pure declarations: no state, no timing.
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_NO,
    FETCH_LO,
    FETCH_HI,
    PUSH
  } fetch_state_t;

  localparam logic [15:0] MAP0_BASE   = 16'h9800;
  localparam logic [15:0] MAP1_BASE   = 16'h9C00;
  localparam logic [15:0] TILE_BASE_U = 16'h8000;
  localparam logic [15:0] TILE_BASE_S = 16'h9000;
  localparam int          TILE_PX     = 8;

  // Per-line parameters captured on line_start; row is already (scy+ly) mod 256.
  typedef struct packed {
    logic [7:0] row;
    logic [4:0] col0;
    logic       map_sel;
    logic       tile_sel;
  } line_cfg_t;

  function automatic logic [15:0] map_addr(input logic sel, input logic [7:0] row,
                                           input logic [4:0] col);
    return (sel ? MAP1_BASE : MAP0_BASE) + {6'd0, row[7:3], col};
  endfunction

  function automatic logic [15:0] tile_addr(input logic sel, input logic [7:0] no,
                                            input logic [7:0] row);
    logic [15:0] off;
    off = sel ? {4'd0, no, 4'd0} : {{4{no[7]}}, no, 4'd0};
    return (sel ? TILE_BASE_U : TILE_BASE_S) + off + {12'd0, row[2:0], 1'b0};
  endfunction

endpackage

// File: rtl/ppu_pixel_fifo.sv
// Circular pixel FIFO: one 8-pixel tile row written per cycle, one pixel popped per cycle.
// Read data is combinational from the head; caller must keep writes within free and pops within count.
module ppu_pixel_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int BPP   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr,
  input  logic [TILE_PX*BPP-1:0]   wr_data,
  input  logic                     pop,
  output logic [BPP-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BPP-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  assign rd_data = mem[rd_ptr];
  assign free    = CW'(DEPTH) - count;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(TILE_PX);
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (wr ? CW'(TILE_PX) : CW'(0)) - (pop ? CW'(1) : CW'(0));
    end
  end

  // Pixel 0 of the write word is the leftmost and lands at the tail first.
  always_ff @(posedge clk) begin
    if (wr) begin
      for (int i = 0; i < TILE_PX; i++) begin
        mem[wr_ptr + AW'(i)] <= wr_data[i*BPP +: BPP];
      end
    end
  end

endmodule

// File: rtl/ppu_bg_fetcher.sv
// Background fetcher: map byte, tile lo/hi fetch into a pixel FIFO, palette-mapped output one cycle after pop.
// VRAM reads hold vram_rd/vram_addr until vram_valid; tile pushes stall while fewer than 8 entries are free.
module ppu_bg_fetcher
  import ppu_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LINE_WIDTH = 160,
  parameter int BPP        = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           line_start,
  input  logic [7:0]     ly,
  input  logic [7:0]     scx,
  input  logic [7:0]     scy,
  input  logic           map_sel,
  input  logic           tile_sel,
  input  logic           bg_en,
  input  logic [7:0]     bgp,
  output logic           vram_rd,
  output logic [15:0]    vram_addr,
  input  logic           vram_valid,
  input  logic [7:0]     vram_data,
  output logic [BPP-1:0] px_out,
  output logic           px_valid,
  output logic           line_done,
  output logic           busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(LINE_WIDTH + 1);

  fetch_state_t           state;
  line_cfg_t              cfg;
  line_cfg_t              cfg_new;
  logic [4:0]             tile_col;
  logic [7:0]             lo;
  logic [7:0]             hi;
  logic [2:0]             discard;
  logic [PW-1:0]          pix_cnt;
  logic                   active;
  logic                   last_pend;
  logic [BPP-1:0]         fifo_px;
  logic [BPP-1:0]         colour;
  logic [CW-1:0]          fifo_count;
  logic [CW-1:0]          fifo_free;
  logic [TILE_PX*BPP-1:0] push_data;
  logic                   handshake;
  logic                   push;
  logic                   pop;
  logic                   line_end;
  logic                   flush;

  always_comb begin
    cfg_new.row      = scy + ly;
    cfg_new.col0     = scx[7:3];
    cfg_new.map_sel  = map_sel;
    cfg_new.tile_sel = tile_sel;
  end

  always_comb begin
    push_data = '0;
    for (int i = 0; i < TILE_PX; i++) begin
      push_data[i*BPP +: BPP] = BPP'({hi[7-i], lo[7-i]});
    end
  end

  assign handshake = vram_rd & vram_valid;
  assign pop       = active && (fifo_count != '0) && !line_start;
  assign line_end  = pop && (discard == 3'd0) && (pix_cnt == PW'(LINE_WIDTH - 1));
  assign push      = (state == PUSH) && (fifo_free >= CW'(TILE_PX)) && !line_start && !line_end;
  assign flush     = line_start | line_end;
  assign colour    = bg_en ? fifo_px : '0;

  ppu_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .BPP   (BPP)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr      (push),
    .wr_data (push_data),
    .pop     (pop),
    .rd_data (fifo_px),
    .count   (fifo_count),
    .free    (fifo_free)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cfg       <= '0;
      tile_col  <= '0;
      lo        <= '0;
      hi        <= '0;
      discard   <= '0;
      pix_cnt   <= '0;
      active    <= 1'b0;
      last_pend <= 1'b0;
      vram_rd   <= 1'b0;
      vram_addr <= 16'h0000;
      px_out    <= '0;
      px_valid  <= 1'b0;
      line_done <= 1'b0;
      busy      <= 1'b0;
    end else if (line_start) begin
      // Also the abort path: any in-flight request and pending line_done are dropped.
      state     <= FETCH_NO;
      cfg       <= cfg_new;
      tile_col  <= '0;
      discard   <= scx[2:0];
      pix_cnt   <= '0;
      active    <= 1'b1;
      last_pend <= 1'b0;
      vram_rd   <= 1'b1;
      vram_addr <= map_addr(map_sel, cfg_new.row, scx[7:3]);
      px_out    <= '0;
      px_valid  <= 1'b0;
      line_done <= 1'b0;
      busy      <= 1'b1;
    end else begin
      last_pend <= line_end;
      line_done <= last_pend;
      if (line_done) busy <= 1'b0;

      px_valid <= 1'b0;
      px_out   <= '0;
      if (pop) begin
        if (discard != 3'd0) begin
          discard <= discard - 3'd1;
        end else begin
          px_valid <= 1'b1;
          px_out   <= BPP'(bgp >> {colour, 1'b0});
          pix_cnt  <= pix_cnt + 1'b1;
        end
      end

      if (line_end) begin
        active  <= 1'b0;
        state   <= IDLE;
        vram_rd <= 1'b0;
      end else begin
        case (state)
          FETCH_NO: if (handshake) begin
            vram_addr <= tile_addr(cfg.tile_sel, vram_data, cfg.row);
            state     <= FETCH_LO;
          end
          FETCH_LO: if (handshake) begin
            lo        <= vram_data;
            vram_addr <= vram_addr + 16'd1;
            state     <= FETCH_HI;
          end
          FETCH_HI: if (handshake) begin
            hi      <= vram_data;
            vram_rd <= 1'b0;
            state   <= PUSH;
          end
          PUSH: if (push) begin
            tile_col  <= tile_col + 5'd1;
            vram_rd   <= 1'b1;
            vram_addr <= map_addr(cfg.map_sel, cfg.row, cfg.col0 + tile_col + 5'd1);
            state     <= FETCH_NO;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ppu_bg_fetcher.sv
// Directed bench for ppu_bg_fetcher: VRAM responder with optional wait states, pixel/address logging
// and a reference pixel model for full-line comparisons.
module tb_ppu_bg_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic [7:0]  ly, scx, scy, bgp;
  logic        map_sel, tile_sel, bg_en;
  logic        vram_rd;
  logic [15:0] vram_addr;
  logic        vram_valid;
  logic [7:0]  vram_data;
  logic [1:0]  px_out;
  logic        px_valid, line_done, busy;

  always #5 clk = ~clk;

  ppu_bg_fetcher #(.FIFO_DEPTH(16), .LINE_WIDTH(160), .BPP(2)) dut (
    .clk(clk), .rst(rst), .line_start(line_start), .ly(ly), .scx(scx), .scy(scy),
    .map_sel(map_sel), .tile_sel(tile_sel), .bg_en(bg_en), .bgp(bgp),
    .vram_rd(vram_rd), .vram_addr(vram_addr), .vram_valid(vram_valid), .vram_data(vram_data),
    .px_out(px_out), .px_valid(px_valid), .line_done(line_done), .busy(busy)
  );

  logic [7:0]  mem [0:65535];
  int          checks = 0, errors = 0;
  int          delay = 0;
  bit          noise = 0;
  logic [15:0] addr_log[$];
  logic [1:0]  px_log[$];
  int          done_cnt = 0, busy_bad = 0, stab_checks = 0, stab_bad = 0, rd_idle = 0;
  logic [7:0]  c_scx, c_scy, c_ly, c_bgp;
  logic        c_ms, c_ts, c_be;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change only 1 time unit after a falling edge, so at each falling edge the inputs
  // still hold the values the previous rising edge sampled.
  initial begin : responder
    logic        prev_rd, prev_valid, hs;
    logic [15:0] prev_addr;
    int          wcnt;
    prev_rd = 0; prev_valid = 0; prev_addr = 0; wcnt = 0;
    vram_valid = 0; vram_data = 0;
    forever begin
      @(negedge clk);
      hs = prev_rd && prev_valid;
      if (hs) addr_log.push_back(prev_addr);
      if (prev_rd && vram_rd && !hs && !line_start && !rst) begin
        stab_checks++;
        if (vram_addr !== prev_addr) stab_bad++;
      end
      if (px_valid) px_log.push_back(px_out);
      if (line_done) begin
        done_cnt++;
        if (!busy) busy_bad++;
      end
      if (vram_rd && !busy) rd_idle++;
      if (vram_rd) begin
        if (hs || !prev_rd || line_start || rst) wcnt = 0;
        vram_valid = (wcnt >= delay);
        vram_data  = mem[vram_addr];
        wcnt++;
      end else begin
        vram_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        vram_data  = 8'($urandom);
        wcnt = 0;
      end
      prev_rd = vram_rd; prev_valid = vram_valid; prev_addr = vram_addr;
    end
  end

  function automatic logic [1:0] model_px(input int k);
    int p, row, col, no, ta, b, c;
    logic [7:0] lo_b, hi_b;
    p   = k + (c_scx % 8);
    row = (int'(c_scy) + int'(c_ly)) % 256;
    col = (int'(c_scx) / 8 + p / 8) % 32;
    no  = mem[(c_ms ? 32'h9C00 : 32'h9800) + 32 * (row / 8) + col];
    ta  = c_ts ? 32'h8000 + no * 16 : 32'h9000 + ((no >= 128) ? no - 256 : no) * 16;
    ta  = ta + 2 * (row % 8);
    lo_b = mem[ta];
    hi_b = mem[ta + 1];
    b = 7 - (p % 8);
    c = c_be ? int'({hi_b[b], lo_b[b]}) : 0;
    return c_bgp[2*c +: 2];
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic start_line(input logic [7:0] sx, input logic [7:0] sy, input logic [7:0] y,
                            input logic ms, input logic ts, input logic be, input logic [7:0] pal);
    c_scx = sx; c_scy = sy; c_ly = y; c_ms = ms; c_ts = ts; c_be = be; c_bgp = pal;
    scx = sx; scy = sy; ly = y; map_sel = ms; tile_sel = ts; bg_en = be; bgp = pal;
    addr_log.delete();
    px_log.delete();
    line_start = 1'b1;
    cyc(1);
    line_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < 5000) begin cyc(1); n++; end
    cyc(5);
    check({tag, "_line_done"}, done_cnt - d0, 1);
  endtask

  task automatic wait_px(input string tag, input int target);
    int n;
    n = 0;
    while (px_log.size() < target && n < 3000) begin cyc(1); n++; end
    check({tag, "_reach"}, px_log.size() >= target, 1);
  endtask

  task automatic check_line(input string tag);
    int nbad;
    nbad = 0;
    check({tag, "_npx"}, px_log.size(), 160);
    for (int i = 0; i < px_log.size() && i < 160; i++)
      if (px_log[i] !== model_px(i)) nbad++;
    check({tag, "_pxbad"}, nbad, 0);
    check({tag, "_idle"}, {busy, vram_rd}, 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_rd"}, vram_rd, 0);
    check({tag, "_addr"}, vram_addr, 16'h0000);
    check({tag, "_px"}, px_out, 0);
    check({tag, "_pxv"}, px_valid, 0);
    check({tag, "_done"}, line_done, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin : stim
    int n0, d0;
    rst = 1; line_start = 0; ly = 0; scx = 0; scy = 0;
    map_sel = 0; tile_sel = 1; bg_en = 1; bgp = 8'hE4;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    cyc(3);
    check_reset_outs("reset");
    rst = 0;
    cyc(2);
    check("idle_busy", busy, 0);

    // Basic tile: map 0x01, lo=FF hi=00 -> colour 1 -> bgp E4 gives 01
    mem[16'h9800] = 8'h01; mem[16'h8010] = 8'hFF; mem[16'h8011] = 8'h00;
    start_line(8'h00, 8'h00, 8'h00, 0, 1, 1, 8'hE4);
    check("t1_rd_first", vram_rd, 1);
    check("t1_busy_first", busy, 1);
    check("t1_addr_first", vram_addr, 16'h9800);
    wait_done("t1");
    check("t1_a0", addr_log[0], 16'h9800);
    check("t1_a1", addr_log[1], 16'h8010);
    check("t1_a2", addr_log[2], 16'h8011);
    for (int i = 0; i < 8; i++) check($sformatf("t1_px%0d", i), px_log[i], 2'b01);
    check("t1_px8", px_log[8], 2'b00);
    check_line("t1");

    // Signed tile addressing
    mem[16'h9800] = 8'h80;
    start_line(8'h00, 8'h00, 8'h00, 0, 0, 1, 8'hE4);
    wait_done("t2a");
    check("t2a_a1", addr_log[1], 16'h8800);
    check("t2a_a2", addr_log[2], 16'h8801);
    mem[16'h9800] = 8'h7F;
    start_line(8'h00, 8'h00, 8'h03, 0, 0, 1, 8'hE4);
    wait_done("t2b");
    check("t2b_a0", addr_log[0], 16'h9800);
    check("t2b_a1", addr_log[1], 16'h97F6);
    check("t2b_a2", addr_log[2], 16'h97F7);

    // Column wrap 31 -> 0
    start_line(8'hF8, 8'h00, 8'h00, 0, 1, 1, 8'hE4);
    wait_done("t3");
    check("t3_a0", addr_log[0], 16'h981F);
    check("t3_a3", addr_log[3], 16'h9800);
    check("t3_a6", addr_log[6], 16'h9801);
    check_line("t3");

    for (int i = 16'h8000; i < 16'hA000; i++) mem[i] = 8'((i * 37 + (i >> 5)) ^ (i >> 3));

    // Fine scroll discard, map 1, row 15
    start_line(8'h03, 8'h05, 8'h0A, 1, 1, 1, 8'h1B);
    wait_done("t4");
    check("t4_a0", addr_log[0], 16'h9C20);
    check_line("t4");

    // Same line with 3 wait states per read and valid noise while idle
    delay = 3; noise = 1;
    start_line(8'h03, 8'h05, 8'h0A, 1, 1, 1, 8'h1B);
    wait_done("t5");
    check_line("t5");
    delay = 0; noise = 0;

    // Signed tiles, row wrap (F0+20=10), column wrap, discard 5
    start_line(8'hFD, 8'hF0, 8'h20, 0, 0, 1, 8'h93);
    wait_done("t6");
    check("t6_a0", addr_log[0], 16'h985F);
    check_line("t6");

    // Background disabled: every pixel is bgp[1:0]
    start_line(8'h05, 8'h00, 8'h00, 0, 1, 0, 8'h93);
    wait_done("t7");
    check("t7_px0", px_log[0], 2'b11);
    check_line("t7");

    // Abort at pixel 50
    start_line(8'h03, 8'h05, 8'h0A, 1, 1, 1, 8'h1B);
    wait_px("ab", 50);
    start_line(8'h00, 8'h00, 8'h00, 0, 1, 1, 8'hE4);
    check("ab_rd", vram_rd, 1);
    check("ab_addr_hi", vram_addr[15:8], 8'h98);
    check("ab_pxv", px_valid, 0);
    wait_done("ab");
    check("ab_a0", addr_log[0], 16'h9800);
    check_line("ab");

    // Reset at pixel 80, with line_start held during reset
    start_line(8'hFD, 8'hF0, 8'h20, 0, 0, 1, 8'h93);
    wait_px("rs", 80);
    rst = 1;
    cyc(1);
    check_reset_outs("rs_in");
    line_start = 1;
    cyc(1);
    check("rs_ovr_busy", busy, 0);
    check("rs_ovr_rd", vram_rd, 0);
    rst = 0; line_start = 0;
    cyc(1);
    check_reset_outs("rs_after");
    n0 = px_log.size(); d0 = done_cnt;
    cyc(100);
    check("rs_no_px", px_log.size(), n0);
    check("rs_no_done", done_cnt, d0);

    // Recovery line after reset
    start_line(8'h03, 8'h05, 8'h0A, 1, 1, 1, 8'h1B);
    wait_done("rec");
    check_line("rec");

    check("busy_at_done", busy_bad, 0);
    check("addr_stable", stab_bad, 0);
    check("stab_seen", stab_checks > 0, 1);
    check("rd_while_idle", rd_idle, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
